// File: rtl/mem_copy_sequencer.sv
// mem_copy_sequencer: runs one bulk line-copy job. Issues source-line read
// requests throttled by outstanding-read credits, converts accepted processed
// lines into destination-line write requests, and pulses done once every
// write has been acknowledged.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   start, src_cl_addr, dst_cl_addr,
//   num_lines                        job launch; inputs captured on start in IDLE
//   busy, done                       job status (registered)
//   rd_req_valid, rd_req_addr        read request (registered)
//   rd_almfull, rd_rsp_valid         read channel throttle and responses
//   wr_data_valid, wr_data_ready     processed-line handshake (ready is combinational)
//   wr_req_valid, wr_req_addr        write request (registered)
//   wr_almfull, wr_ack_valid         write channel throttle and acknowledgements
//
// Optional build macro MEM_COPY_SEQ_PERF_EN adds perf_cycles, perf_rd_stall
// and perf_wr_stall counters, cleared on an accepted start and frozen after done.

module mem_copy_sequencer #(
    parameter int unsigned ADDR_W          = 42,
    parameter int unsigned LEN_W           = 32,
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_cl_addr,
    input  logic [ADDR_W-1:0] dst_cl_addr,
    input  logic [LEN_W-1:0]  num_lines,
    output logic              busy,
    output logic              done,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_almfull,
    input  logic              rd_rsp_valid,
    input  logic              wr_data_valid,
    output logic              wr_data_ready,
    output logic              wr_req_valid,
    output logic [ADDR_W-1:0] wr_req_addr,
    input  logic              wr_almfull,
    input  logic              wr_ack_valid
`ifdef MEM_COPY_SEQ_PERF_EN
    ,
    output logic [63:0]       perf_cycles,
    output logic [31:0]       perf_rd_stall,
    output logic [31:0]       perf_wr_stall
`endif
);

    localparam logic [LEN_W-1:0] MAX_OUT_L = LEN_W'(MAX_OUTSTANDING);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rd_issued;
    logic [LEN_W-1:0]  rd_rsp_count;
    logic [LEN_W-1:0]  wr_issued;
    logic [LEN_W-1:0]  wr_ack_count;

    logic              active;
    logic              xfer;
    logic [LEN_W-1:0]  outstanding;
    logic              rsp_accept;
    logic              ack_accept;
    logic              rd_issue;
    logic              wr_accept;
    logic [LEN_W-1:0]  ack_count_next;

    // Issue/accept decisions for the current cycle
    always_comb begin
        active         = (state != S_IDLE);
        xfer           = (state == S_RUN) || (state == S_DRAIN);
        outstanding    = rd_issued - rd_rsp_count;
        // Responses/acks beyond what was issued are dropped so counts never overrun
        rsp_accept     = active && rd_rsp_valid && (rd_rsp_count < rd_issued);
        ack_accept     = active && wr_ack_valid && (wr_ack_count < wr_issued);
        // A response returning this cycle frees the credit the new read consumes
        rd_issue       = (state == S_RUN) && (rd_issued < len_q) && !rd_almfull
                         && ((outstanding < MAX_OUT_L) || rsp_accept);
        wr_data_ready  = xfer && !wr_almfull && (wr_issued < len_q);
        wr_accept      = wr_data_valid && wr_data_ready;
        ack_count_next = ack_accept ? (wr_ack_count + ONE_L) : wr_ack_count;
    end

    // Job state, counters and registered request outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            rd_issued    <= '0;
            rd_rsp_count <= '0;
            wr_issued    <= '0;
            wr_ack_count <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_req_valid <= 1'b0;
            rd_req_addr  <= '0;
            wr_req_valid <= 1'b0;
            wr_req_addr  <= '0;
        end else begin
            rd_req_valid <= 1'b0;
            wr_req_valid <= 1'b0;

            if (rsp_accept) begin
                rd_rsp_count <= rd_rsp_count + ONE_L;
            end
            wr_ack_count <= ack_count_next;

            if (rd_issue) begin
                rd_req_valid <= 1'b1;
                rd_req_addr  <= src_q + ADDR_W'(rd_issued);
                rd_issued    <= rd_issued + ONE_L;
            end

            if (wr_accept) begin
                wr_req_valid <= 1'b1;
                wr_req_addr  <= dst_q + ADDR_W'(wr_issued);
                wr_issued    <= wr_issued + ONE_L;
            end

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        src_q        <= src_cl_addr;
                        dst_q        <= dst_cl_addr;
                        len_q        <= num_lines;
                        rd_issued    <= '0;
                        rd_rsp_count <= '0;
                        wr_issued    <= '0;
                        wr_ack_count <= '0;
                        busy         <= 1'b1;
                        state        <= (num_lines == '0) ? S_FINISH : S_RUN;
                    end
                end
                S_RUN: begin
                    if (rd_issued == len_q) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (ack_count_next == len_q) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    // First FINISH cycle raises done; the second retires the job
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_COPY_SEQ_PERF_EN
    // Job performance counters; cleared on accepted start, idle once busy drops
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles   <= '0;
            perf_rd_stall <= '0;
            perf_wr_stall <= '0;
        end else if ((state == S_IDLE) && start) begin
            perf_cycles   <= '0;
            perf_rd_stall <= '0;
            perf_wr_stall <= '0;
        end else begin
            if (busy) begin
                perf_cycles <= perf_cycles + 64'd1;
            end
            if ((state == S_RUN) && (rd_issued < len_q) && !rd_issue) begin
                perf_rd_stall <= perf_rd_stall + 32'd1;
            end
            if (busy && wr_data_valid && !wr_data_ready) begin
                perf_wr_stall <= perf_wr_stall + 32'd1;
            end
        end
    end
`endif

endmodule
